arb_grant_fifo: RTL and testbench

//  Requester-side companion of the weighted round-robin arbiter.
//  - Presents nReq valid/ready data sources to the arbiter as `request`, and throttles it with `trigger`.
//  - Consumes the arbiter's one-hot `grant`: completes the winner's handshake and pushes its

---
 rtl/arb_grant_fifo.sv | 121 ++++++++++++
 tb/tb_arb_grant_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_grant_fifo.sv
// Requester-side companion of the weighted round-robin arbiter: forwards requests, accepts the
// one-hot grant winner into a DEPTH-entry FIFO, drains it downstream. Option: ARB_GRANT_FIFO_STATS_EN.
module arb_grant_fifo #(
   parameter int nReq   = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [nReq-1:0]                req_valid,
   input  logic [nReq-1:0][DATA_W-1:0]    req_data,
   output logic [nReq-1:0]                req_ready,
   output logic [nReq-1:0]                request,
   output logic                           trigger,
   input  logic [nReq-1:0]                grant,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [$clog2(nReq)-1:0]        out_src,
   input  logic                           out_ready,
   output logic                           err_grant
`ifdef ARB_GRANT_FIFO_STATS_EN
   ,
   output logic [nReq-1:0][15:0]          grant_cnt
`endif
);

   localparam int SRC_W = $clog2(nReq);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = SRC_W + DATA_W;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;

   logic             grant_onehot;
   logic             grant_bad;
   logic             push;
   logic             pop;
   logic             err_ev;
   logic [SRC_W-1:0] push_src;

   always_comb begin
      request      = req_valid;
      trigger      = (count_q != CNT_W'(DEPTH));
      out_valid    = (count_q != '0);
      {out_src, out_data} = mem_q[rd_ptr_q];
      err_grant    = err_q;

      grant_onehot = $onehot(grant);
      grant_bad    = |(grant & ~req_valid);
      // Handshakes never complete during reset, even though trigger may still read 1.
      push         = trigger & grant_onehot & ~grant_bad & ~reset;
      err_ev       = trigger & (|grant) & (~grant_onehot | grant_bad);
      req_ready    = push ? grant : '0;
      pop          = out_valid & out_ready;

      push_src = '0;
      for (int i = 0; i < nReq; i++) begin
         if (grant[i]) push_src = SRC_W'(i);
      end

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {push_src, req_data[push_src]};

      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      err_d = err_q | err_ev;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Storage is qualified by count, so it needs no reset.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

`ifdef ARB_GRANT_FIFO_STATS_EN
   logic [nReq-1:0][15:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      for (int i = 0; i < nReq; i++) begin
         if (push && grant[i] && grant_cnt_q[i] != 16'hFFFF)
            grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end
      grant_cnt = grant_cnt_q;
   end

   always_ff @(posedge clock) begin
      if (reset) grant_cnt_q <= '0;
      else       grant_cnt_q <= grant_cnt_d;
   end
`endif

   a_no_push_full: assert property (@(posedge clock) disable iff (reset)
      !(push && count_q == CNT_W'(DEPTH)));
   a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
      !(pop && count_q == '0));

endmodule

// File: tb/tb_arb_grant_fifo.sv
// Self-checking bench for arb_grant_fifo: directed steps plus random traffic against a queue model.
module tb_arb_grant_fifo;

   localparam int NREQ  = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic                      clock;
   logic                      reset;
   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0][DW-1:0]   req_data;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ-1:0]           request;
   logic                      trigger;
   logic [NREQ-1:0]           grant;
   logic                      out_valid;
   logic [DW-1:0]             out_data;
   logic [1:0]                out_src;
   logic                      out_ready;
   logic                      err_grant;
`ifdef ARB_GRANT_FIFO_STATS_EN
   logic [NREQ-1:0][15:0]     grant_cnt;
`endif

   arb_grant_fifo #(.nReq(NREQ), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .request   (request),
      .trigger   (trigger),
      .grant     (grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .err_grant (err_grant)
`ifdef ARB_GRANT_FIFO_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]    src;
      logic [DW-1:0] data;
   } ent_t;

   int   checks   = 0;
   int   failures = 0;
   ent_t q[$];
   bit   err_m;
   int   cnt_m [NREQ];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      err_m = 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
   endtask

   // Inputs are set by the caller shortly after a rising edge; check, then advance one cycle.
   task automatic step();
      int              n1;
      int              idx;
      logic [NREQ-1:0] acc_e;
      bit              room;
      bit              ev;
      ent_t            e;
      #2;
      n1    = $countones(grant);
      room  = (q.size() != DEPTH);
      acc_e = (!reset && room && n1 == 1 && (grant & req_valid) != 0) ? grant : '0;
      ev    = !reset && room && grant != 0 && (n1 != 1 || (grant & ~req_valid) != 0);
      chk("request",   64'(request),   64'(req_valid));
      chk("req_ready", 64'(req_ready), 64'(acc_e));
      chk("trigger",   64'(trigger),   64'(room));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_data", 64'(out_data), 64'(q[0].data));
         chk("out_src",  64'(out_src),  64'(q[0].src));
      end
      chk("err_grant", 64'(err_grant), 64'(err_m));
`ifdef ARB_GRANT_FIFO_STATS_EN
      for (int i = 0; i < NREQ; i++) chk("grant_cnt", 64'(grant_cnt[i]), 64'(cnt_m[i]));
`endif
      @(posedge clock);
      if (reset) begin
         model_reset();
      end else begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (acc_e != 0) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (acc_e[i]) idx = i;
            e.src  = 2'(idx);
            e.data = req_data[idx];
            q.push_back(e);
            if (cnt_m[idx] < 65535) cnt_m[idx]++;
         end
         if (ev) err_m = 1'b1;
      end
      #1;
   endtask

   task automatic rand_data();
      for (int i = 0; i < NREQ; i++) req_data[i] = $urandom;
   endtask

   initial begin
      int r;
      int pick;
      logic [NREQ-1:0] v;
      model_reset();

      // 1: reset held with all valid and a grant
      reset = 1'b1; req_valid = 4'hF; grant = 4'b0001; out_ready = 1'b0;
      rand_data();
      @(posedge clock); #1;
      repeat (5) step();
      reset = 1'b0;

      // 2: single push from requester 2
      req_valid = 4'b0100; grant = 4'b0100; req_data[2] = 32'hA5A5_0002;
      step();
      req_valid = '0; grant = '0;
      chk("t2_out_valid", 64'(out_valid), 64'd1);
      chk("t2_out_data",  64'(out_data),  64'hA5A5_0002);
      chk("t2_out_src",   64'(out_src),   64'd2);

      // 3: fill, ignored 5th grant, one pop re-enables trigger next cycle
      reset = 1'b1; step(); reset = 1'b0;
      out_ready = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         rand_data(); grant = 4'(1 << k); step();
      end
      chk("t3_full_trigger", 64'(trigger), 64'd0);
      grant = 4'b0001; step();
      chk("t3_ignored_err", 64'(err_grant), 64'd0);
      grant = '0; out_ready = 1'b1; step();
      out_ready = 1'b0;
      chk("t3_trigger_back", 64'(trigger), 64'd1);

      // 4: reduce to two entries, then push+pop every cycle
      out_ready = 1'b1; step();
      for (int c = 0; c < 10; c++) begin
         rand_data(); grant = 4'(1 << (c % 4)); step();
      end
      grant = '0; out_ready = 1'b0;

      // 5: non-one-hot grant
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 4'hF; grant = 4'b0110; step();
      chk("t5_err_set", 64'(err_grant), 64'd1);
      grant = '0; out_ready = 1'b1;
      repeat (3) step();
      chk("t5_err_sticky", 64'(err_grant), 64'd1);
      reset = 1'b1; step(); reset = 1'b0;
      chk("t5_err_cleared", 64'(err_grant), 64'd0);

      // random traffic
      for (int c = 0; c < 2000; c++) begin
         reset     = ($urandom_range(0, 199) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         v         = 4'($urandom);
         req_valid = v;
         rand_data();
         r = $urandom_range(0, 15);
         if (r < 10) begin
            grant = '0;
            if (v != 0) begin
               do pick = $urandom_range(0, NREQ - 1); while (!v[pick]);
               grant = 4'(1 << pick);
            end
         end else if (r == 13) begin
            grant = 4'(1 << $urandom_range(0, NREQ - 1));
         end else if (r == 14) begin
            grant = 4'($urandom);
         end else begin
            grant = '0;
         end
         step();
      end
      reset = 1'b0; grant = '0;

`ifdef ARB_GRANT_FIFO_STATS_EN
      // 6: weighted 1/2/3/4 pattern, then saturation of requester 0
      reset = 1'b1; step(); reset = 1'b0;
      out_ready = 1'b1; req_valid = 4'hF;
      for (int n = 0; n < 100; n++) begin
         r = n % 10;
         pick = (r < 1) ? 0 : (r < 3) ? 1 : (r < 6) ? 2 : 3;
         grant = 4'(1 << pick); rand_data(); step();
      end
      for (int i = 0; i < NREQ; i++) chk("t6_ratio", 64'(grant_cnt[i]), 64'(10 * (i + 1)));
      grant = 4'b0001;
      for (int n = 0; n < 70000; n++) step();
      chk("t6_saturate", 64'(grant_cnt[0]), 64'hFFFF);
      grant = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
